// File: rtl/hdmi_blk_pkg.sv
// Shared definitions for the HDMI <-> 8x8 block conversion paths.
// Holds the block geometry, the pixel/word types and the HDMI timing
// constants that the input and output paths must agree on.
package hdmi_blk_pkg;

  localparam int BLOCK_SIZE = 8;

  typedef logic signed [7:0] pix_t;

  // One pixel as stored in a strip buffer word; a word holds N of these,
  // laid out as {cb lanes, cr lanes, y lanes}.
  typedef struct packed {
    pix_t cb;
    pix_t cr;
    pix_t y;
  } ycc_word_t;

  // HDMI porch/sync timing used by the block-to-HDMI output path.
  localparam int H_FRONT_PORCH = 88;
  localparam int H_SYNC_WIDTH  = 44;
  localparam int H_BACK_PORCH  = 148;
  localparam int V_FRONT_PORCH = 4;
  localparam int V_SYNC_WIDTH  = 5;
  localparam int V_BACK_PORCH  = 36;

  // Counter width that stays at least 1 bit for a range of one value.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/strip_buffer.sv
// Two-bank simple dual-port RAM holding one 8-line strip per bank.
// Ports:
//   clk                       clock (no reset: storage only)
//   we, wr_bank, wr_addr,     write port: word wr_data into bank wr_bank
//   wr_data
//   rd_bank, rd_addr          read port address, sampled every cycle
//   rd_data                   registered read data (one cycle after address)
module strip_buffer
  import hdmi_blk_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int W     = 48,
  parameter int AW    = width_of(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          wr_bank,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_bank,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [2][DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_bank][wr_addr] <= wr_data;
    rd_data <= mem[rd_bank][rd_addr];
  end

endmodule

// File: rtl/hdmi_to_blocks.sv
// HDMI raster stream to 8x8 block stream converter.
// Eight raster lines are written into one bank of a ping-pong strip buffer;
// a completed strip is then read out block by block (left to right, each
// block line by line) while the next strip fills the other bank.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   hdmi_v_sync                rising edge starts a frame
//   hdmi_h_sync                rising edge ends a line
//   hdmi_data_valid            active pixel beat, N pixels per beat
//   hdmi_data_y/cr/cb          pixel components, lane 0 = leftmost pixel
//   blk_valid                  block data beat
//   blk_data_y/cr/cb           block data, N pixels of one block line
//   blk_sob / blk_eob          first / last beat of a block
//   blk_sof                    first beat of a frame (with blk_sob)
//   err_overflow               sticky: strip dropped, reader was busy
//   err_format                 sticky: short line or v_sync mid-strip
// Stream protocol: there is no backpressure on either side. A beat moves
// on every cycle its valid is high; markers and data are only meaningful
// while blk_valid is high and are 0 otherwise.
module hdmi_to_blocks
  import hdmi_blk_pkg::*;
#(
  parameter int N     = 2,
  parameter int X_RES = 2160,
  parameter int Y_RES = 1200
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    hdmi_v_sync,
  input  logic                    hdmi_h_sync,
  input  logic                    hdmi_data_valid,
  input  logic signed [N-1:0][7:0] hdmi_data_y,
  input  logic signed [N-1:0][7:0] hdmi_data_cr,
  input  logic signed [N-1:0][7:0] hdmi_data_cb,
  output logic                    blk_valid,
  output logic signed [N-1:0][7:0] blk_data_y,
  output logic signed [N-1:0][7:0] blk_data_cr,
  output logic signed [N-1:0][7:0] blk_data_cb,
  output logic                    blk_sob,
  output logic                    blk_eob,
  output logic                    blk_sof,
  output logic                    err_overflow,
  output logic                    err_format
);

  localparam int WPL   = X_RES / N;
  localparam int BPB   = BLOCK_SIZE / N;
  localparam int DEPTH = BLOCK_SIZE * WPL;
  localparam int NBLK  = X_RES / BLOCK_SIZE;
  localparam int W     = 24 * N;
  localparam int AW    = width_of(DEPTH);
  localparam int CW    = width_of(WPL);
  localparam int EW    = width_of(BPB);
  localparam int BW    = width_of(NBLK);
  localparam int FW    = $clog2(Y_RES + 1);

  localparam logic [0:0] RD_IDLE = 1'b0;
  localparam logic [0:0] RD_READ = 1'b1;

  // Writer state
  logic          v_sync_q, h_sync_q;
  logic [CW-1:0] col;
  logic [2:0]    line_in_strip;
  logic [FW-1:0] frame_line;
  logic          wr_sel, sof_pending;

  // Reader state
  logic [0:0]    rd_state;
  logic          rd_bank, strip_sof;
  logic [EW-1:0] blk_elem;
  logic [2:0]    blk_line;
  logic [BW-1:0] blk;

  // Read pipeline
  logic [AW-1:0] rd_addr_q;
  logic          rd_bank_q;
  logic          p1_valid, p1_sob, p1_eob, p1_sof;
  logic          p2_valid, p2_sob, p2_eob, p2_sof;
  logic [W-1:0]  ram_q, out_word;

  logic          v_rise, h_rise, beat_ok, line_end, strip_done;
  logic          rd_busy, rd_last, rd_free, rd_start;
  logic [AW-1:0] wr_addr, rd_addr_next;
  logic [W-1:0]  wr_data;

  always_comb begin
    v_rise     = hdmi_v_sync & ~v_sync_q;
    h_rise     = hdmi_h_sync & ~h_sync_q;
    beat_ok    = hdmi_data_valid && (frame_line < FW'(Y_RES));
    line_end   = beat_ok && (col == CW'(WPL - 1));
    strip_done = line_end && (line_in_strip == 3'd7);
    rd_busy    = (rd_state == RD_READ);
    rd_last    = rd_busy && (blk == BW'(NBLK - 1)) && (blk_line == 3'd7)
                 && (blk_elem == EW'(BPB - 1));
    // A reader on its final beat can hand over to a new strip with no gap.
    rd_free    = !rd_busy || rd_last;
    rd_start   = strip_done && rd_free;
    wr_addr    = AW'(line_in_strip * WPL) + AW'(col);
    wr_data    = {hdmi_data_cb, hdmi_data_cr, hdmi_data_y};
    rd_addr_next = AW'(blk * BPB) + AW'(blk_line * WPL) + AW'(blk_elem);
  end

  // Writer. Later assignments take priority: a v_sync on the last beat of a
  // strip lets the strip complete, then restarts the frame counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_sync_q      <= 1'b0;
      h_sync_q      <= 1'b0;
      col           <= '0;
      line_in_strip <= '0;
      frame_line    <= '0;
      wr_sel        <= 1'b0;
      sof_pending   <= 1'b0;
      err_overflow  <= 1'b0;
      err_format    <= 1'b0;
    end else begin
      v_sync_q <= hdmi_v_sync;
      h_sync_q <= hdmi_h_sync;
      if (beat_ok) begin
        if (line_end) begin
          col           <= '0;
          line_in_strip <= line_in_strip + 3'd1;
          frame_line    <= frame_line + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      // Short line: drop the partial line, keep the line index.
      if (h_rise && (col != '0) && !line_end) begin
        col        <= '0;
        err_format <= 1'b1;
      end
      if (strip_done) begin
        if (rd_free) begin
          wr_sel      <= ~wr_sel;
          sof_pending <= 1'b0;
        end else begin
          // Keep wr_sel: the next strip overwrites the dropped one.
          err_overflow <= 1'b1;
        end
      end
      if (v_rise) begin
        if ((line_in_strip != 3'd0) && !strip_done) err_format <= 1'b1;
        col           <= '0;
        line_in_strip <= '0;
        frame_line    <= '0;
        sof_pending   <= 1'b1;
      end
    end
  end

  // Reader FSM: block_elem fastest, then block_line, then block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state  <= RD_IDLE;
      rd_bank   <= 1'b0;
      strip_sof <= 1'b0;
      blk_elem  <= '0;
      blk_line  <= '0;
      blk       <= '0;
    end else if (rd_start) begin
      rd_state  <= RD_READ;
      rd_bank   <= wr_sel;
      strip_sof <= sof_pending;
      blk_elem  <= '0;
      blk_line  <= '0;
      blk       <= '0;
    end else if (rd_busy) begin
      if (rd_last) rd_state <= RD_IDLE;
      if (blk_elem == EW'(BPB - 1)) begin
        blk_elem <= '0;
        if (blk_line == 3'd7) begin
          blk_line <= '0;
          blk      <= (blk == BW'(NBLK - 1)) ? '0 : blk + 1'b1;
        end else begin
          blk_line <= blk_line + 3'd1;
        end
      end else begin
        blk_elem <= blk_elem + 1'b1;
      end
    end
  end

  strip_buffer #(.DEPTH(DEPTH), .W(W), .AW(AW)) u_buf (
    .clk     (clk),
    .we      (beat_ok),
    .wr_bank (wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_bank (rd_bank_q),
    .rd_addr (rd_addr_q),
    .rd_data (ram_q)
  );

  // Address register -> RAM read -> output register; markers ride along.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_q <= '0;
      rd_bank_q <= 1'b0;
      p1_valid  <= 1'b0;
      p1_sob    <= 1'b0;
      p1_eob    <= 1'b0;
      p1_sof    <= 1'b0;
      p2_valid  <= 1'b0;
      p2_sob    <= 1'b0;
      p2_eob    <= 1'b0;
      p2_sof    <= 1'b0;
      blk_valid <= 1'b0;
      blk_sob   <= 1'b0;
      blk_eob   <= 1'b0;
      blk_sof   <= 1'b0;
      out_word  <= '0;
    end else begin
      rd_addr_q <= rd_addr_next;
      rd_bank_q <= rd_bank;
      p1_valid  <= rd_busy;
      p1_sob    <= rd_busy && (blk_line == 3'd0) && (blk_elem == '0);
      p1_eob    <= rd_busy && (blk_line == 3'd7) && (blk_elem == EW'(BPB - 1));
      p1_sof    <= rd_busy && strip_sof && (blk == '0) && (blk_line == 3'd0)
                   && (blk_elem == '0);
      p2_valid  <= p1_valid;
      p2_sob    <= p1_sob;
      p2_eob    <= p1_eob;
      p2_sof    <= p1_sof;
      blk_valid <= p2_valid;
      blk_sob   <= p2_sob;
      blk_eob   <= p2_eob;
      blk_sof   <= p2_sof;
      out_word  <= p2_valid ? ram_q : '0;
    end
  end

  assign blk_data_y  = out_word[8*N-1:0];
  assign blk_data_cr = out_word[16*N-1:8*N];
  assign blk_data_cb = out_word[24*N-1:16*N];

endmodule

// File: tb/tb_hdmi_to_blocks.sv
// Self-checking bench for hdmi_to_blocks in a small configuration
// (N=2, X_RES=16, Y_RES=16). The reference model tracks lines of the
// current strip in an array and, when a strip completes, queues the whole
// expected block-order readout with the edge each beat must appear at.
module tb_hdmi_to_blocks;

  localparam int N     = 2;
  localparam int XR    = 16;
  localparam int YR    = 16;
  localparam int WPL   = XR / N;
  localparam int BPB   = 8 / N;
  localparam int DEPTH = 8 * WPL;
  localparam int NBLK  = XR / 8;
  localparam int WW    = 24 * N;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                     v = 1'b0, h = 1'b0, dv = 1'b0;
  logic signed [N-1:0][7:0] dy = '0, dcr = '0, dcb = '0;
  logic                     blk_valid, blk_sob, blk_eob, blk_sof;
  logic signed [N-1:0][7:0] blk_data_y, blk_data_cr, blk_data_cb;
  logic                     err_overflow, err_format;

  hdmi_to_blocks #(.N(N), .X_RES(XR), .Y_RES(YR)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .hdmi_v_sync     (v),
    .hdmi_h_sync     (h),
    .hdmi_data_valid (dv),
    .hdmi_data_y     (dy),
    .hdmi_data_cr    (dcr),
    .hdmi_data_cb    (dcb),
    .blk_valid       (blk_valid),
    .blk_data_y      (blk_data_y),
    .blk_data_cr     (blk_data_cr),
    .blk_data_cb     (blk_data_cb),
    .blk_sob         (blk_sob),
    .blk_eob         (blk_eob),
    .blk_sof         (blk_sof),
    .err_overflow    (err_overflow),
    .err_format      (err_format)
  );

  // ---------------- checking ----------------
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [WW+2:0] exp_q[$];    // {sof, sob, eob, cb, cr, y}
  int            exp_t_q[$];  // edge count at which the beat is visible

  logic [WW-1:0] m_cur[8][WPL];
  int   m_col, m_line, m_fl, m_free_at;
  logic m_vq, m_hq, m_sofp, m_fmt, m_ovf;

  task automatic model_reset();
    m_col = 0; m_line = 0; m_fl = 0; m_free_at = 0;
    m_vq = 0; m_hq = 0; m_sofp = 0; m_fmt = 0; m_ovf = 0;
    exp_q.delete();
    exp_t_q.delete();
  endtask

  // Queue a full strip readout: blocks left to right, lines top to bottom.
  task automatic emit_strip(input int e, input logic sof);
    int idx = 0;
    for (int b = 0; b < NBLK; b++)
      for (int r = 0; r < 8; r++)
        for (int el = 0; el < BPB; el++) begin
          exp_q.push_back({sof && b == 0 && r == 0 && el == 0,
                           r == 0 && el == 0, r == 7 && el == BPB - 1,
                           m_cur[r][b*BPB+el]});
          exp_t_q.push_back(e + 3 + idx);
          idx++;
        end
  endtask

  // One input cycle, sampled by the DUT at edge e.
  task automatic model_step(input logic mv, input logic mh, input logic mdv,
                            input logic [WW-1:0] w, input int e);
    logic vr, hr, ok, lend, sdone;
    int   col0, line0;
    vr = mv && !m_vq;
    hr = mh && !m_hq;
    col0 = m_col;
    line0 = m_line;
    ok = mdv && (m_fl < YR);
    lend = 0;
    sdone = 0;
    if (ok) begin
      m_cur[m_line][m_col] = w;
      if (m_col == WPL - 1) begin
        lend = 1;
        sdone = (m_line == 7);
        m_col = 0;
        m_line = (m_line + 1) % 8;
        m_fl++;
      end else m_col++;
    end
    if (hr && col0 != 0 && !lend) begin
      m_fmt = 1;
      m_col = 0;
    end
    if (sdone) begin
      if (e >= m_free_at) begin
        emit_strip(e, m_sofp);
        m_free_at = e + DEPTH;
        m_sofp = 0;
      end else m_ovf = 1;
    end
    if (vr) begin
      if (line0 != 0 && !sdone) m_fmt = 1;
      m_col = 0; m_line = 0; m_fl = 0; m_sofp = 1;
    end
    m_vq = mv;
    m_hq = mh;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic mv, input logic mh, input logic mdv,
                       input logic [WW-1:0] w);
    @(negedge clk);
    v = mv; h = mh; dv = mdv;
    {dcb, dcr, dy} = w;
    model_step(mv, mh, mdv, w, cyc + 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, '0);
  endtask

  task automatic vsync();
    drive(1, 0, 0, '0);
    drive(0, 0, 0, '0);
  endtask

  function automatic logic [WW-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[WW-1:0];
  endfunction

  // nbeats valid beats; pat>=0 puts y pixel = pat*16 + column; then an
  // h_sync pulse and idle cycles when gap > 0. vlast raises v_sync on the
  // final beat.
  task automatic send_line(input int nbeats, input int gap, input int pat,
                           input logic vlast = 0);
    logic [WW-1:0] w;
    for (int c = 0; c < nbeats; c++) begin
      w = rand_word();
      if (pat >= 0) begin
        w[7:0]  = 8'(pat * 16 + 2 * c);
        w[15:8] = 8'(pat * 16 + 2 * c + 1);
      end
      drive(vlast && c == nbeats - 1, 0, 1, w);
    end
    if (gap > 0) begin
      drive(0, 1, 0, '0);
      idle(gap - 1);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      idle(1);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    idle(4);
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_ovf"}, err_overflow, m_ovf);
    chk({tag, "_fmt"}, err_format, m_fmt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    v = 0; h = 0; dv = 0; dy = '0; dcr = '0; dcb = '0;
    #1;
    chk("rst_valid", blk_valid, 0);
    chk("rst_markers", {blk_sob, blk_eob, blk_sof}, 0);
    chk("rst_data", {blk_data_cb, blk_data_cr, blk_data_y}, 0);
    chk("rst_errs", {err_overflow, err_format}, 0);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (blk_valid) begin
        if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          chk("beat", {blk_sof, blk_sob, blk_eob, blk_data_cb, blk_data_cr, blk_data_y},
              exp_q.pop_front());
          chk("beat_time", cyc, exp_t_q.pop_front());
        end
      end else begin
        chk("idle_markers", {blk_sob, blk_eob, blk_sof}, 0);
        if (exp_q.size() != 0 && exp_t_q[0] <= cyc) begin
          chk("missing_beat", cyc, exp_t_q[0]);
          void'(exp_q.pop_front());
          void'(exp_t_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    do_reset();
    idle(2);

    // Pattern strip, then a random strip, then lines beyond Y_RES.
    vsync();
    for (int l = 0; l < 8; l++) send_line(WPL, 2, l);
    for (int l = 0; l < 8; l++) send_line(WPL, 1, -1);
    for (int l = 0; l < 8; l++) send_line(WPL, 1, -1);
    wait_drain(400);
    chk("beyond_yres_idle", blk_valid, 0);
    check_flags("frame1");

    // Back-to-back strips with no blanking: handover on the reader's last beat.
    vsync();
    for (int l = 0; l < 16; l++) send_line(WPL, 0, -1);
    wait_drain(400);
    check_flags("contig");

    // v_sync on the final beat of a strip: strip completes, next one is a new frame.
    vsync();
    for (int l = 0; l < 7; l++) send_line(WPL, 1, -1);
    send_line(WPL, 1, -1, 1);
    for (int l = 0; l < 8; l++) send_line(WPL, 1, -1);
    wait_drain(400);
    check_flags("vs_last");

    // Short line: discarded, next full line takes its index.
    vsync();
    send_line(5, 2, -1);
    for (int l = 0; l < 8; l++) send_line(WPL, 1, l);
    wait_drain(400);
    check_flags("short_line");

    // v_sync mid-strip after a clean reset.
    do_reset();
    vsync();
    for (int l = 0; l < 3; l++) send_line(WPL, 1, -1);
    vsync();
    for (int l = 0; l < 8; l++) send_line(WPL, 1, -1);
    wait_drain(400);
    check_flags("vs_mid");

    // Reset in the middle of readout, then recover with a fresh frame.
    vsync();
    for (int l = 0; l < 8; l++) send_line(WPL, 1, -1);
    idle(12);
    do_reset();
    idle(3);
    chk("post_rst_valid", blk_valid, 0);
    vsync();
    for (int l = 0; l < 8; l++) send_line(WPL, 1, l);
    wait_drain(400);
    check_flags("recover");

    // Random frames: random blanking, occasional short lines.
    for (int f = 0; f < 4; f++) begin
      vsync();
      for (int l = 0; l < $urandom_range(8, 20); l++) begin
        if ($urandom_range(0, 7) == 0) send_line($urandom_range(1, WPL - 1), $urandom_range(1, 3), -1);
        else send_line(WPL, $urandom_range(0, 3), -1);
      end
      idle($urandom_range(0, 5));
    end
    wait_drain(800);
    check_flags("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case a wait never resolves.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
